// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter (icmu = master 0, dcmu = master 1).
// The grant is registered and is held for the whole cyc tenure, so bursts are
// never split. Contention is resolved round-robin.
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog that flags a bus error
// after TIMEOUT_CYCLES stb cycles without ack/err.
//
// state | meaning
// IDLE  | no owner, all slave-side outputs low
// OWN0  | icmu owns the bus
// OWN1  | dcmu owns the bus
module wb_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  m_cyc_i,
  input  logic [1:0]  m_stb_i,
  input  logic [1:0]  m_we_i,
  input  logic [7:0]  m_sel_i,
  input  logic [59:0] m_addr_i,
  input  logic [5:0]  m_cti_i,
  input  logic [3:0]  m_bte_i,
  input  logic [63:0] m_data_i,
  output logic [31:0] m_data_o,
  output logic [1:0]  m_ack_o,
  output logic [1:0]  m_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [29:0] s_addr_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t state;
  logic   last;      // master served most recently; loses the next contention
  logic   stb_raw;   // owner's stb before any timeout masking
  logic   tmo;       // watchdog fired this cycle

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  assign tmo = (state != IDLE) && stb_raw && !s_ack_i && !s_err_i &&
               (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  assign grant_o  = {state == OWN1, state == OWN0};
  assign m_data_o = s_data_i;
  assign m_ack_o  = {2{s_ack_i}} & grant_o;
  assign m_err_o  = {2{s_err_i | tmo}} & grant_o;

  // Slave-side mux: pass the owner's signals through, everything low when idle.
  always_comb begin
    stb_raw  = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_addr_o = '0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    s_data_o = '0;
    if (state == OWN0) begin
      stb_raw  = m_stb_i[0];
      s_cyc_o  = m_cyc_i[0];
      s_we_o   = m_we_i[0];
      s_sel_o  = m_sel_i[3:0];
      s_addr_o = m_addr_i[29:0];
      s_cti_o  = m_cti_i[2:0];
      s_bte_o  = m_bte_i[1:0];
      s_data_o = m_data_i[31:0];
    end else if (state == OWN1) begin
      stb_raw  = m_stb_i[1];
      s_cyc_o  = m_cyc_i[1];
      s_we_o   = m_we_i[1];
      s_sel_o  = m_sel_i[7:4];
      s_addr_o = m_addr_i[59:30];
      s_cti_o  = m_cti_i[5:3];
      s_bte_o  = m_bte_i[3:2];
      s_data_o = m_data_i[63:32];
    end
    s_stb_o = stb_raw;
    // A timed-out cycle is cut off on the slave side in the same cycle the error goes out.
    if (tmo) begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
    end
  end

  // Ownership FSM: grant on request, hold until the owner drops cyc, hand over directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m_cyc_i == 2'b01)      state <= OWN0;
          else if (m_cyc_i == 2'b10) state <= OWN1;
          else if (m_cyc_i == 2'b11) state <= last ? OWN0 : OWN1;
        end
        OWN0: begin
          if (!m_cyc_i[0] || tmo) begin
            last  <= 1'b0;
            state <= (m_cyc_i[1] && !tmo) ? OWN1 : IDLE;
          end
        end
        OWN1: begin
          if (!m_cyc_i[1] || tmo) begin
            last  <= 1'b1;
            state <= (m_cyc_i[0] && !tmo) ? OWN0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog: counts unanswered stb cycles of the current tenure.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || tmo || s_ack_i || s_err_i) begin
      tmo_cnt <= '0;
    end else if ((state == OWN0 && !m_cyc_i[0]) || (state == OWN1 && !m_cyc_i[1])) begin
      tmo_cnt <= '0;
    end else if (stb_raw) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter, with a short watchdog (TIMEOUT_CYCLES = 8).
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [7:0]  m_sel_i;
  logic [59:0] m_addr_i;
  logic [5:0]  m_cti_i;
  logic [3:0]  m_bte_i;
  logic [63:0] m_data_i;
  logic [31:0] m_data_o;
  logic [1:0]  m_ack_o, m_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [29:0] s_addr_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [31:0] s_data_o;
  logic [31:0] s_data_i;
  logic        s_ack_i, s_err_i;
  logic [1:0]  grant_o;

  int vectors = 0;
  int miscompares = 0;

  wb_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_addr_i(m_addr_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i), .m_data_i(m_data_i),
    .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_addr_o(s_addr_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0; m_addr_i = '0;
    m_cti_i = '0; m_bte_i = '0; m_data_i = '0;
    s_data_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    step(); step();
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_scyc", s_cyc_o, 0);
    rst = 1'b0;

    // 1: single m0 read at word address 0x40
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_sel_i = 8'h0F; m_addr_i = 60'h40;
    #1 chk("t1_pre_grant", grant_o, 2'b00);
    step();
    chk("t1_grant", grant_o, 2'b01);
    chk("t1_scyc", s_cyc_o, 1);
    chk("t1_sstb", s_stb_o, 1);
    chk("t1_addr", s_addr_o, 30'h40);
    chk("t1_noack", m_ack_o, 2'b00);
    step();
    s_ack_i = 1'b1; s_data_i = 32'hDEADBEEF;
    #1 chk("t1_ack", m_ack_o, 2'b01);
    chk("t1_data", m_data_o, 32'hDEADBEEF);
    step();
    s_ack_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();
    chk("t1_idle", grant_o, 2'b00);
    s_ack_i = 1'b1;
    #1 chk("idle_ack_ignored", m_ack_o, 2'b00);
    chk("idle_scyc", s_cyc_o, 0);
    s_ack_i = 1'b0;

    // 2: contention, last=0 so m1 wins first; direct handover; round-robin
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_addr_i = {30'h123, 30'h40};
    step();
    chk("t2_grant_m1", grant_o, 2'b10);
    chk("t2_addr_m1", s_addr_o, 30'h123);
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    step();
    chk("t2_handover", grant_o, 2'b01);
    chk("t2_addr_m0", s_addr_o, 30'h40);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();
    chk("t2_idle", grant_o, 2'b00);
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    step();
    chk("t2_rr_m1", grant_o, 2'b10);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    step();
    chk("t2_rr_m0", grant_o, 2'b01);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();

    // 3: m0 4-beat incrementing burst, m1 requests at beat 2
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_cti_i = 6'b000_010; m_bte_i = 4'b00_00;
    step();
    chk("t3_cti", s_cti_o, 3'b010);
    chk("t3_bte", s_bte_o, 2'b00);
    for (int b = 0; b < 4; b++) begin
      s_ack_i = 1'b1;
      if (b == 1) begin m_cyc_i = 2'b11; m_stb_i = 2'b11; end
      #1 chk("t3_beat_grant", grant_o, 2'b01);
      chk("t3_beat_ack", m_ack_o, 2'b01);
      step();
    end
    s_ack_i = 1'b0; m_cyc_i = 2'b10; m_stb_i = 2'b10; m_cti_i = '0;
    #1 chk("t3_held", grant_o, 2'b01);
    step();
    chk("t3_to_m1", grant_o, 2'b10);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();

    // 4: m1 write sel=0011, slave errors
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b10; m_sel_i = 8'h3F;
    m_data_i = {32'hCAFEF00D, 32'h11111111};
    step();
    chk("t4_grant", grant_o, 2'b10);
    chk("t4_we", s_we_o, 1);
    chk("t4_sel", s_sel_o, 4'b0011);
    chk("t4_wdata", s_data_o, 32'hCAFEF00D);
    s_err_i = 1'b1;
    #1 chk("t4_err", m_err_o, 2'b10);
    chk("t4_noack", m_ack_o, 2'b00);
    step();
    s_err_i = 1'b0;
    #1 chk("t4_held", grant_o, 2'b10);
    m_cyc_i = 2'b00; m_stb_i = 2'b00; m_we_i = 2'b00;
    step();
    chk("t4_idle", grant_o, 2'b00);

    // 5: reset mid-burst while m1 owns the bus
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    step();
    s_ack_i = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("t5_grant", grant_o, 2'b00);
    chk("t5_scyc", s_cyc_o, 0);
    chk("t5_sstb", s_stb_o, 0);
    chk("t5_ack", m_ack_o, 2'b00);
    rst = 1'b0; s_ack_i = 1'b0;
    step();
    chk("t5_regrant", grant_o, 2'b10);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();

    // 6: unresponsive slave
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    step();
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      chk("t6_tmo_err", m_err_o, (k == 8) ? 2'b01 : 2'b00);
      chk("t6_tmo_stb", s_stb_o, (k == 8) ? 0 : 1);
      step();
    end
    chk("t6_tmo_idle", grant_o, 2'b00);
`else
    for (int k = 0; k < 100; k++) begin
      chk("t6_stb", s_stb_o, 1);
      chk("t6_noerr", m_err_o, 2'b00);
      step();
    end
    chk("t6_grant", grant_o, 2'b01);
`endif
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
